// File: rtl/rv32c_pkg.sv
// Shared definitions for the RV32C fetch aligner.
// Holds the aligner FSM states, the quadrant that marks a 32-bit opcode,
// the PC step sizes and the compressed-halfword test.
package rv32c_pkg;

  typedef enum logic {
    S_RUN,
    S_ALIGN
  } alignState_t;

  localparam logic [1:0]  QUADRANT_32 = 2'b11;
  localparam logic [31:0] HALF_STEP   = 32'd2;
  localparam logic [31:0] WORD_STEP   = 32'd4;

  // A halfword starts a compressed instruction unless its low two bits are 11.
  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != QUADRANT_32;
  endfunction

endpackage

// File: rtl/rv32c_fetch_aligner.sv
// Instruction fetch aligner for the RV32IC core.
// Pulls aligned 32-bit words from instruction memory and splits them into a
// stream of 16-bit and 32-bit instructions, including 32-bit instructions
// that straddle a word boundary. The spare upper halfword of a fetched word
// is kept in hbuf until it is either issued on its own or joined with the
// low half of the next word. Redirects flush everything and restart at the
// new PC; a redirect into the upper half of a word goes through S_ALIGN,
// which fetches that word only to capture its upper halfword.
module rv32c_fetch_aligner
  import rv32c_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRECT_PC,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  input  logic        iFETCH_VALID,
  input  logic [31:0] iFETCH_DATA,
  output logic        oINSTR_VALID,
  input  logic        iINSTR_READY,
  output logic [31:0] oINSTR,
  output logic [31:0] oINSTR_PC,
  output logic        oINSTR_IS_C
);

  alignState_t state, stateNext;

  logic [31:0] pc, pcNext;
  logic [31:0] fpc, fpcNext;
  logic [15:0] hbuf, hbufNext;
  logic        hbufValid, hbufValidNext;

  logic        instrValidNext;
  logic [31:0] instrNext;
  logic [31:0] instrPcNext;
  logic        instrIsCNext;

  logic        slotFree;
  logic        fetchReq;
  logic        fetchAccept;
  logic        bufIsC;
  logic        lowIsC;
  logic [31:0] redirectPc;
  logic [31:0] redirectFpc;

  assign slotFree    = !oINSTR_VALID || iINSTR_READY;
  assign bufIsC      = is_compressed(hbuf);
  assign lowIsC      = is_compressed(iFETCH_DATA[15:0]);
  assign redirectPc  = iREDIRECT_PC & 32'hFFFF_FFFE;
  assign redirectFpc = iREDIRECT_PC & 32'hFFFF_FFFC;
  assign fetchAccept = fetchReq && iFETCH_VALID;

  assign oFETCH_REQ  = fetchReq;
  assign oFETCH_ADDR = fpc;

  // Fetch request: S_ALIGN always fetches; S_RUN fetches only when the output
  // slot can take a new instruction and hbuf does not already hold one.
  always_comb begin
    fetchReq = 1'b0;
    if (!iRST) begin
      case (state)
        S_ALIGN: fetchReq = 1'b1;
        S_RUN:   fetchReq = slotFree && !(hbufValid && bufIsC);
        default: fetchReq = 1'b0;
      endcase
    end
  end

  // Next-state and next-output logic; a redirect overrides every other action.
  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    fpcNext        = fpc;
    hbufNext       = hbuf;
    hbufValidNext  = hbufValid;
    instrValidNext = oINSTR_VALID;
    instrNext      = oINSTR;
    instrPcNext    = oINSTR_PC;
    instrIsCNext   = oINSTR_IS_C;

    if (iREDIRECT) begin
      pcNext         = redirectPc;
      fpcNext        = redirectFpc;
      hbufValidNext  = 1'b0;
      instrValidNext = 1'b0;
      stateNext      = iREDIRECT_PC[1] ? S_ALIGN : S_RUN;
    end else begin
      case (state)
        S_ALIGN: begin
          if (slotFree) begin
            instrValidNext = 1'b0;
          end
          if (fetchAccept) begin
            hbufNext      = iFETCH_DATA[31:16];
            hbufValidNext = 1'b1;
            fpcNext       = fpc + WORD_STEP;
            stateNext     = S_RUN;
          end
        end

        S_RUN: begin
          if (slotFree) begin
            instrValidNext = 1'b0;
            if (hbufValid && bufIsC) begin
              instrValidNext = 1'b1;
              instrNext      = {16'h0000, hbuf};
              instrPcNext    = pc;
              instrIsCNext   = 1'b1;
              pcNext         = pc + HALF_STEP;
              hbufValidNext  = 1'b0;
            end else if (fetchAccept) begin
              instrValidNext = 1'b1;
              instrPcNext    = pc;
              fpcNext        = fpc + WORD_STEP;
              if (hbufValid) begin
                instrNext    = {iFETCH_DATA[15:0], hbuf};
                instrIsCNext = 1'b0;
                pcNext       = pc + WORD_STEP;
                hbufNext     = iFETCH_DATA[31:16];
              end else if (lowIsC) begin
                instrNext     = {16'h0000, iFETCH_DATA[15:0]};
                instrIsCNext  = 1'b1;
                pcNext        = pc + HALF_STEP;
                hbufNext      = iFETCH_DATA[31:16];
                hbufValidNext = 1'b1;
              end else begin
                instrNext    = iFETCH_DATA;
                instrIsCNext = 1'b0;
                pcNext       = pc + WORD_STEP;
              end
            end
          end
        end

        default: begin
          stateNext = S_RUN;
        end
      endcase
    end
  end

  // Aligner state registers: FSM, instruction PC, fetch PC and halfword buffer.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= RESET_PC[1] ? S_ALIGN : S_RUN;
      pc        <= RESET_PC;
      fpc       <= {RESET_PC[31:2], 2'b00};
      hbuf      <= 16'h0000;
      hbufValid <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      fpc       <= fpcNext;
      hbuf      <= hbufNext;
      hbufValid <= hbufValidNext;
    end
  end

  // Registered instruction slot presented to decode.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oINSTR_VALID <= 1'b0;
      oINSTR       <= 32'h0000_0000;
      oINSTR_PC    <= 32'h0000_0000;
      oINSTR_IS_C  <= 1'b0;
    end else begin
      oINSTR_VALID <= instrValidNext;
      oINSTR       <= instrNext;
      oINSTR_PC    <= instrPcNext;
      oINSTR_IS_C  <= instrIsCNext;
    end
  end

endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
// Testbench for rv32c_fetch_aligner.
// The main instance runs against a 256-word memory that repeats across the
// address space. Expected instructions are derived from memory contents by
// walking the PC halfword by halfword; each redirect or reset queues a fresh
// expected stream, and a monitor pops and compares on every handshake.
// A second instance starts at the top of the address space to show the wrap.
module tb_rv32c_fetch_aligner;

  localparam int STREAM_LEN = 160;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        isC;
  } expItem_t;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iREDIRECT;
  logic [31:0] iREDIRECT_PC;
  logic        oFETCH_REQ;
  logic [31:0] oFETCH_ADDR;
  logic        iFETCH_VALID;
  logic [31:0] iFETCH_DATA;
  logic        oINSTR_VALID;
  logic        iINSTR_READY;
  logic [31:0] oINSTR;
  logic [31:0] oINSTR_PC;
  logic        oINSTR_IS_C;

  logic        wrapRst;
  logic        wrapFetchReq;
  logic [31:0] wrapFetchAddr;
  logic [31:0] wrapFetchData;
  logic        wrapInstrValid;
  logic [31:0] wrapInstr;
  logic [31:0] wrapInstrPc;
  logic        wrapInstrIsC;

  logic [31:0] mem [0:255];
  expItem_t    expQ[$];
  expItem_t    nextQ[$];
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;

  always #5 iCLK = ~iCLK;

  assign iFETCH_DATA   = mem[oFETCH_ADDR[9:2]];
  assign wrapFetchData = (wrapFetchAddr == 32'hFFFF_FFFC) ? 32'h0010_0093 :
                         (wrapFetchAddr == 32'h0000_0000) ? 32'h0000_0013 : 32'h0000_0001;

  rv32c_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREDIRECT(iREDIRECT), .iREDIRECT_PC(iREDIRECT_PC),
    .oFETCH_REQ(oFETCH_REQ), .oFETCH_ADDR(oFETCH_ADDR),
    .iFETCH_VALID(iFETCH_VALID), .iFETCH_DATA(iFETCH_DATA),
    .oINSTR_VALID(oINSTR_VALID), .iINSTR_READY(iINSTR_READY),
    .oINSTR(oINSTR), .oINSTR_PC(oINSTR_PC), .oINSTR_IS_C(oINSTR_IS_C)
  );

  rv32c_fetch_aligner #(.RESET_PC(32'hFFFF_FFFC)) wrapDut (
    .iCLK(iCLK), .iRST(wrapRst), .iREDIRECT(1'b0), .iREDIRECT_PC(32'h0000_0000),
    .oFETCH_REQ(wrapFetchReq), .oFETCH_ADDR(wrapFetchAddr),
    .iFETCH_VALID(1'b1), .iFETCH_DATA(wrapFetchData),
    .oINSTR_VALID(wrapInstrValid), .iINSTR_READY(1'b1),
    .oINSTR(wrapInstr), .oINSTR_PC(wrapInstrPc), .oINSTR_IS_C(wrapInstrIsC)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Halfword of the repeating memory image at a byte address.
  function automatic logic [15:0] memHalf(input logic [31:0] addr);
    logic [31:0] w;
    w = mem[addr[9:2]];
    return addr[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected instruction sequence when execution starts at startPc.
  task automatic buildStream(input logic [31:0] startPc);
    logic [31:0] p;
    logic [15:0] lo;
    expItem_t    e;
    nextQ.delete();
    p = startPc & 32'hFFFF_FFFE;
    for (int i = 0; i < STREAM_LEN; i++) begin
      lo   = memHalf(p);
      e.pc = p;
      if (lo[1:0] != 2'b11) begin
        e.instr = {16'h0000, lo};
        e.isC   = 1'b1;
        p       = p + 32'd2;
      end else begin
        e.instr = {memHalf(p + 32'd2), lo};
        e.isC   = 1'b0;
        p       = p + 32'd4;
      end
      nextQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic fv, input logic rdy);
    iREDIRECT    = redir;
    iREDIRECT_PC = rpc;
    iFETCH_VALID = fv;
    iINSTR_READY = rdy;
  endtask

  task automatic nextCycle;
    @(posedge iCLK);
    #1;
  endtask

  task automatic doRedirect(input logic [31:0] target, input logic fv, input logic rdy);
    buildStream(target);
    applyStimulus(1'b1, target, fv, rdy);
  endtask

  // One cycle with no fetch data and no consumption so memory can be edited.
  task automatic quiesce;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
  endtask

  task automatic randomizeMem;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 0) w[17:16] = 2'b11;
      mem[i] = w;
    end
  endtask

  function automatic logic [31:0] randTarget();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FF00 | ($urandom & 32'h0000_00FF);
    return $urandom & 32'h0000_03FF;
  endfunction

  // Scoreboard monitor: compares each handshake against the expected stream.
  always @(negedge iCLK) begin
    expItem_t e;
    if (iRST) begin
      expQ = nextQ;
    end else begin
      if (oINSTR_VALID && iINSTR_READY) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedIssue", oINSTR_PC, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("sbInstr", oINSTR, e.instr);
          checkOutput("sbPc", oINSTR_PC, e.pc);
          checkOutput("sbIsC", {31'h0, oINSTR_IS_C}, {31'h0, e.isC});
          consumed++;
        end
      end
      if (iREDIRECT) expQ = nextQ;
    end
  end

  initial begin
    int since;
    int startConsumed;
    logic fv;
    logic rdy;

    wrapRst = 1'b1;
    iRST    = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    randomizeMem();
    mem[0] = 32'h4501_8082;
    buildStream(32'h0000_0000);

    // Reset state
    @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("rstFetchReq", {31'h0, oFETCH_REQ}, 32'h0);
    checkOutput("rstValid", {31'h0, oINSTR_VALID}, 32'h0);
    checkOutput("rstInstr", oINSTR, 32'h0);
    checkOutput("rstPc", oINSTR_PC, 32'h0);
    checkOutput("rstIsC", {31'h0, oINSTR_IS_C}, 32'h0);
    nextCycle();

    // Two compressed instructions from one word
    iRST = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t1Req", {31'h0, oFETCH_REQ}, 32'h1);
    checkOutput("t1Addr0", oFETCH_ADDR, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t1Instr0", oINSTR, 32'h0000_8082);
    checkOutput("t1Pc0", oINSTR_PC, 32'h0);
    checkOutput("t1IsC0", {31'h0, oINSTR_IS_C}, 32'h1);
    checkOutput("t1NoFetch", {31'h0, oFETCH_REQ}, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t1Instr1", oINSTR, 32'h0000_4501);
    checkOutput("t1Pc1", oINSTR_PC, 32'h2);
    checkOutput("t1Addr4", oFETCH_ADDR, 32'h4);
    nextCycle();

    // Straddling 32-bit instruction
    quiesce();
    mem[0] = 32'h0513_0001;
    mem[1] = 32'h1234_0050;
    doRedirect(32'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t2Addr0", oFETCH_ADDR, 32'h0);
    checkOutput("t2Valid0", {31'h0, oINSTR_VALID}, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t2Instr0", oINSTR, 32'h0000_0001);
    checkOutput("t2Addr4", oFETCH_ADDR, 32'h4);
    checkOutput("t2Req4", {31'h0, oFETCH_REQ}, 32'h1);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t2Straddle", oINSTR, 32'h0050_0513);
    checkOutput("t2StraddlePc", oINSTR_PC, 32'h2);
    checkOutput("t2StraddleIsC", {31'h0, oINSTR_IS_C}, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t2Hbuf", oINSTR, 32'h0000_1234);
    checkOutput("t2HbufPc", oINSTR_PC, 32'h6);
    nextCycle();

    // Redirect into the upper half of a word, then backpressure
    quiesce();
    mem[32'h40] = 32'h8082_FFFF;
    doRedirect(32'h0000_0102, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t3AlignAddr", oFETCH_ADDR, 32'h100);
    checkOutput("t3AlignReq", {31'h0, oFETCH_REQ}, 32'h1);
    checkOutput("t3AlignValid", {31'h0, oINSTR_VALID}, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t3Bubble", {31'h0, oINSTR_VALID}, 32'h0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge iCLK);
      checkOutput("t4HoldValid", {31'h0, oINSTR_VALID}, 32'h1);
      checkOutput("t4HoldInstr", oINSTR, 32'h0000_8082);
      checkOutput("t4HoldPc", oINSTR_PC, 32'h102);
      checkOutput("t4HoldNoReq", {31'h0, oFETCH_REQ}, 32'h0);
      checkOutput("t4HoldAddr", oFETCH_ADDR, 32'h104);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t4ReleaseReq", {31'h0, oFETCH_REQ}, 32'h1);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t4NextPc", oINSTR_PC, 32'h104);
    nextCycle();

    // Redirect in the same cycle as fetch data
    quiesce();
    mem[32'h80] = 32'hAAAA_0004;
    mem[32'h10] = 32'h0000_0013;
    doRedirect(32'h0000_0200, 1'b0, 1'b0);
    nextCycle();
    doRedirect(32'h0000_0040, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t5ReqAt200", oFETCH_ADDR, 32'h200);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge iCLK);
    checkOutput("t5Valid", {31'h0, oINSTR_VALID}, 32'h0);
    checkOutput("t5Addr", oFETCH_ADDR, 32'h40);
    nextCycle();
    @(negedge iCLK);
    checkOutput("t5Instr", oINSTR, 32'h0000_0013);
    checkOutput("t5Pc", oINSTR_PC, 32'h40);
    nextCycle();

    // Randomized traffic with random stalls, fetch latency and redirects
    quiesce();
    randomizeMem();
    doRedirect(randTarget(), 1'b0, 1'b0);
    nextCycle();
    since = 0;
    startConsumed = consumed;
    for (int c = 0; c < 4000; c++) begin
      fv  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (since >= 100 || $urandom_range(0, 24) == 0) begin
        doRedirect(randTarget(), fv, rdy);
        since = 0;
      end else begin
        applyStimulus(1'b0, 32'h0, fv, rdy);
        since++;
      end
      nextCycle();
    end
    checkOutput("randomProgress", {31'h0, (consumed - startConsumed) > 600}, 32'h1);
    quiesce();

    // Start at the last word of the address space
    wrapRst = 1'b0;
    @(negedge iCLK);
    checkOutput("wrapReq", {31'h0, wrapFetchReq}, 32'h1);
    checkOutput("wrapAddrTop", wrapFetchAddr, 32'hFFFF_FFFC);
    nextCycle();
    @(negedge iCLK);
    checkOutput("wrapValid", {31'h0, wrapInstrValid}, 32'h1);
    checkOutput("wrapInstr", wrapInstr, 32'h0010_0093);
    checkOutput("wrapPc", wrapInstrPc, 32'hFFFF_FFFC);
    checkOutput("wrapIsC", {31'h0, wrapInstrIsC}, 32'h0);
    checkOutput("wrapAddr0", wrapFetchAddr, 32'h0);
    nextCycle();
    @(negedge iCLK);
    checkOutput("wrapNextInstr", wrapInstr, 32'h0000_0013);
    checkOutput("wrapNextPc", wrapInstrPc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
